// File: rtl/if_fetch_pkg.sv
// Shared definitions for the tinyMIPS instruction-fetch front end:
// bus widths, the NOP word, fetch FSM encodings and the reset polarity.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord  = 32'h0000_0000;
  localparam logic               RstEnable = 1'b1;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_STALL = 3'd2,
    S_DROP  = 3'd3,
    S_ERR   = 3'd4
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_timer.sv
// Fetch watchdog: counts consecutive unacknowledged request cycles and raises
// a sticky error once TIMEOUT_CYCLES of them have elapsed. Cleared by the
// owning FSM when it leaves the error state.
module if_fetch_timer import if_fetch_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic clear,
  output logic expire,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LastCount = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Expiry fires during the TIMEOUT_CYCLES-th waiting cycle, so the abort
  // takes effect at the edge that ends it.
  assign expire = req && !ack && (cnt_q == LastCount);

  // Wait counter restarts on any ack, on an idle bus, and after expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      if (!req || ack || expire) cnt_q <= '0;
      else                       cnt_q <= cnt_q + 1'b1;
      if (expire)     err <= 1'b1;
      else if (clear) err <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// tinyMIPS instruction fetch: owns the PC, masters the instruction bus and
// presents one {pc, inst} pair per cycle to IF/ID. A one-entry skid buffer
// absorbs a fetch that returns while IF/ID is stalled; a redirect that lands
// while a request is outstanding is handled by draining that request (DROP).
// Optional: define IFETCH_TIMEOUT_EN to add the bus watchdog (if_fetch_timer).
module if_fetch import if_fetch_pkg::*; #(
  parameter logic [InstAddrBus-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   ibus_req_o,
  output logic [InstAddrBus-1:0] ibus_addr_o,
  input  logic                   ibus_ack_i,
  input  logic [InstBus-1:0]     ibus_rdata_i,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid,
  output logic                   fetch_err_o
);

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstAddrBus-1:0] drop_addr_q, drop_addr_d;
  logic [InstAddrBus-1:0] slot_pc_d;
  logic [InstBus-1:0]     slot_inst_q, slot_inst_d;
  logic                   valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [InstAddrBus-1:0] skid_pc_q, skid_pc_d;
  logic [InstBus-1:0]     skid_inst_q, skid_inst_d;
  logic                   done;
  logic                   consumed;
  logic                   timeout;
  logic [InstAddrBus-1:0] target;

  // While draining, the bus keeps showing the abandoned address even though
  // pc_q already points at the branch target.
  assign ibus_req_o  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign ibus_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign done        = ibus_req_o && ibus_ack_i;
  assign consumed    = if_valid && !stall_i;
  assign target      = align_word(branch_target_i);
  assign if_inst     = if_valid ? slot_inst_q : ZeroWord;

`ifdef IFETCH_TIMEOUT_EN
  logic err_clear;
  assign err_clear = branch_flag_i && (state_q == S_ERR);

  if_fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .req   (ibus_req_o),
    .ack   (ibus_ack_i),
    .clear (err_clear),
    .expire(timeout),
    .err   (fetch_err_o)
  );
`else
  // Keeps the watchdog parameter referenced in builds without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout     = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  // Next-state, PC, output-slot and skid-buffer decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    valid_d      = consumed ? 1'b0 : if_valid;
    slot_pc_d    = if_pc;
    slot_inst_d  = slot_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (branch_flag_i) pc_d = target;
      end
      S_FETCH: begin
        if (timeout) begin
          state_d = S_ERR;
        end else if (branch_flag_i) begin
          pc_d         = target;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          if (!done) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (done) begin
          pc_d = pc_q + 32'd4;
          if (!if_valid || !stall_i) begin
            slot_pc_d   = pc_q;
            slot_inst_d = ibus_rdata_i;
            valid_d     = 1'b1;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_inst_d  = ibus_rdata_i;
            state_d      = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (branch_flag_i) begin
          pc_d         = target;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (!stall_i) begin
          slot_pc_d    = skid_pc_q;
          slot_inst_d  = skid_inst_q;
          valid_d      = skid_valid_q;
          skid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_DROP: begin
        if (timeout) begin
          state_d = S_ERR;
        end else begin
          if (branch_flag_i) begin
            pc_d    = target;
            valid_d = 1'b0;
          end
          if (done) state_d = S_FETCH;
        end
      end
      S_ERR: begin
        if (branch_flag_i) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State, PC, output slot and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      if_pc        <= '0;
      slot_inst_q  <= ZeroWord;
      if_valid     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= ZeroWord;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      if_pc        <= slot_pc_d;
      slot_inst_q  <= slot_inst_d;
      if_valid     <= valid_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end of the tinyMIPS pipeline.
- Owns the PC and acts as bus master on the instruction bus (req/ack).
- Delivers one {pc, instruction} pair per cycle to the IF/ID pipeline register as if_pc/if_inst/if_valid.
- Handles downstream stall through a one-entry skid buffer, and branch redirect from ID, including a redirect that arrives while a bus request is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TIMEOUT_CYCLES, 16, consecutive unacknowledged request cycles before a fetch error (used only with IFETCH_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- stall_i  in  1  IF/ID cannot accept this cycle
- branch_flag_i  in  1  redirect request from ID
- branch_target_i  in  32  redirect address
- ibus_req_o  out  1  fetch request
- ibus_addr_o  out  32  fetch address (word aligned)
- ibus_ack_i  in  1  memory ack; rdata valid this cycle
- ibus_rdata_i  in  32  instruction word
- if_pc  out  32  PC of the presented instruction
- if_inst  out  32  presented instruction; ZeroWord (NOP) when !if_valid
- if_valid  out  1  output slot holds a live instruction
- fetch_err_o  out  1  sticky fetch timeout; tied 0 without the macro

Behaviour:
- Reset values (asynchronous):
  - pc_q = RESET_PC
  - state = BOOT
  - if_pc = 0, if_inst = 0, if_valid = 0
  - skid empty
  - ibus_req_o = 0, fetch_err_o = 0
  - rst dominates every other input.
- Bus rules:
  - A transfer completes on a cycle where ibus_req_o && ibus_ack_i.
  - Once raised, req and addr stay stable until ack; the only exception is the ERR abort.
  - Zero-wait ack (ack in the same cycle as req) is legal.
- Slot consumption: the output slot is consumed at any edge where if_valid && !stall_i.
- BOOT state:
  - req = 0 for one cycle.
  - Next state: FETCH.
- FETCH state:
  - req = 1, addr = pc_q.
  - On ack, if the slot is empty or consumed at this edge: slot <= {pc_q, rdata}, if_valid <= 1.
  - On ack, if the slot is full and stall_i = 1: skid <= {pc_q, rdata}, go to STALL.
  - Every ack also does pc_q <= pc_q + 4.
  - Without ack: stay in FETCH; if_valid clears if the slot is consumed.
- STALL state:
  - req = 0.
  - When stall_i = 0: slot <= skid (the old slot is consumed at the same edge), skid empties, go to FETCH.
- DROP state:
  - Entered on a redirect while req is outstanding without ack.
  - req stays high at the old addr until ack; the returning data is discarded.
  - After the ack, go to FETCH at pc_q.
- Latency: ack at edge N gives if_valid = 1 after edge N. Sustained throughput is 1 instruction/cycle with zero-wait memory.
- Redirect (branch_flag_i = 1 at an edge):
  - pc_q <= branch_target_i.
  - Slot and skid are invalidated; an instruction consumed at the same edge is considered delivered.
  - In FETCH with ack in the same cycle: data discarded, stay in FETCH.
  - In FETCH without ack: go to DROP.
  - In DROP: update pc_q, stay in DROP.
  - In STALL: go to FETCH.
- Redirect has priority over stall.
- pc_q wraps modulo 2^32; bits [1:0] of branch_target_i are forced to 0.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- With the macro:
  - A counter increments each cycle req && !ack and clears on ack.
  - When it reaches TIMEOUT_CYCLES: state ERR, req drops (abort), fetch_err_o = 1 (sticky).
  - The next branch_flag_i clears the error and resumes in FETCH at the target.
- Without the macro: no counter, fetch_err_o constant 0, FETCH/DROP wait for ack indefinitely.

Decomposition:
- Shared macro package:
  - ZeroWord, InstAddrBus, InstBus
  - state encodings (BOOT/FETCH/STALL/DROP/ERR)
  - the reset polarity constant
- One natural sub-module: if_fetch_timer (timeout counter plus sticky error), instantiated only under IFETCH_TIMEOUT_EN.

Test Plan:
- Reset release, ack tied 1, rdata = addr ^ 32'hA5A5_0000 -> req at cycle 1; if_valid from cycle 2; if_pc 0, 4, 8 … consecutive, one per cycle.
- stall_i high 3 cycles while slot = 0x8 and ack = 1 -> skid captures 0xC, req low during STALL; release -> 0xC next cycle, then 0x10, no loss or duplication.
- ack low with req at 0x10, branch to 0x100 -> req/addr held at 0x10 until ack, data dropped, next req addr 0x100, if_valid 0 in between.
- Redirect in the same cycle as ack at 0x20, target 0x200 -> 0x20 never presented, next addr 0x200.
- Assert rst mid-request with no clock edge -> req, if_valid, if_pc, if_inst go to 0 immediately; first request after release is at RESET_PC.
- With IFETCH_TIMEOUT_EN: ack low 16 cycles -> fetch_err_o = 1 and req = 0 at cycle 16; branch to 0x40 clears the error and the next req is at 0x40.
